axi_write_slave: RTL



---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_wr_addr_gen.sv | 43 ++++
 rtl/axi_write_slave.sv | 126 ++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state type for the write responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Per-beat AXI address generator: loads the start address, then steps by
// 2^size for INCR bursts and holds for FIXED.
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] start_addr,
  input  logic [2:0]    size,
  input  logic [1:0]    burst,
  input  logic          advance,
  output logic [AW-1:0] addr
);

  logic [2:0]    size_q;
  logic [1:0]    burst_q;
  logic [AW-1:0] step;

  always_comb begin
    step = '0;
    if (burst_q == BURST_INCR)
      step = AW'(1) << size_q;
  end

  // Address wraps silently modulo 2^AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (load) begin
      addr    <= start_addr;
      size_q  <= size;
      burst_q <= burst;
    end else if (advance) begin
      addr    <= addr + step;
    end
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI4 write responder: accepts one burst at a time, commits each beat to
// an SRAM write port and returns one B response per burst.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int AWID_WIDTH   = 4,
  parameter int AWADDR_WIDTH = 10,
  parameter int WDATA_WIDTH  = 64,
  parameter int WSTRB_WIDTH  = WDATA_WIDTH / 8,
  parameter int MEM_AW       = AWADDR_WIDTH - 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AWID_WIDTH-1:0]   AWID,
  input  logic [AWADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [WDATA_WIDTH-1:0]  WDATA,
  input  logic [WSTRB_WIDTH-1:0]  WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [AWID_WIDTH-1:0]   BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_wen,
  output logic [MEM_AW-1:0]       mem_waddr,
  output logic [WDATA_WIDTH-1:0]  mem_wdata,
  output logic [WSTRB_WIDTH-1:0]  mem_wstrb
);

  localparam int LSB = $clog2(WSTRB_WIDTH);

  wr_state_t               state_q, state_n;
  logic [AWID_WIDTH-1:0]   id_q;
  logic [7:0]              len_q;
  logic [7:0]              bcnt;
  logic                    err_q;
  logic [AWADDR_WIDTH-1:0] cur_addr;

  logic aw_hs, w_hs, b_hs;
  logic last_beat, beat_err, acc_err;
  logic unused_lsb;

  assign unused_lsb = ^cur_addr[LSB-1:0];

  always_comb begin
    aw_hs     = AWREADY & AWVALID;
    w_hs      = WREADY & WVALID;
    b_hs      = BVALID & BREADY;
    last_beat = (bcnt == len_q);
    // A WLAST mismatch poisons the beat that carries it.
    beat_err  = err_q | (WLAST != last_beat);
    acc_err   = (AWSIZE > 3'(LSB)) | AWBURST[1];
    state_n   = state_q;
    unique case (state_q)
      ST_IDLE: if (aw_hs)             state_n = ST_DATA;
      ST_DATA: if (w_hs && last_beat) state_n = ST_RESP;
      ST_RESP: if (b_hs)              state_n = ST_IDLE;
      default:                        state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BID       <= '0;
      BRESP     <= RESP_OKAY;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      id_q      <= '0;
      len_q     <= '0;
      bcnt      <= '0;
      err_q     <= 1'b0;
    end else begin
      AWREADY <= (state_n == ST_IDLE);
      WREADY  <= (state_n == ST_DATA);
      BVALID  <= (state_n == ST_RESP);
      mem_wen <= w_hs & ~beat_err;
      if (aw_hs) begin
        id_q  <= AWID;
        len_q <= AWLEN;
        bcnt  <= '0;
        err_q <= acc_err;
      end
      if (w_hs) begin
        mem_waddr <= cur_addr[AWADDR_WIDTH-1:LSB];
        mem_wdata <= WDATA;
        mem_wstrb <= WSTRB;
        bcnt      <= bcnt + 8'd1;
        err_q     <= beat_err;
        if (last_beat) begin
          BID   <= id_q;
          BRESP <= beat_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  axi_wr_addr_gen #(
    .AW(AWADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (aw_hs),
    .start_addr(AWADDR),
    .size      (AWSIZE),
    .burst     (AWBURST),
    .advance   (w_hs),
    .addr      (cur_addr)
  );

endmodule
